// File: rtl/periph_bridge_pkg.sv
// Shared constants and types for the peripheral bridge and its interrupt controller.
package periph_bridge_pkg;
   localparam int         MAX_DEV  = 8;
   localparam int         WIN_SIZE = 16;
   localparam int         WIN_BITS = $clog2(WIN_SIZE);
   localparam int         HW_INT_W = 6;
   localparam logic [7:0] OFF_MASK = 8'hF0;
   localparam logic [7:0] OFF_PEND = 8'hF4;
   localparam logic [7:0] OFF_MODE = 8'hF8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;
endpackage

// File: rtl/periph_irq_ctrl.sv
// Interrupt controller: DevIRQ sampling, edge detect, MASK/PENDING/MODE registers, registered HWInt.
// Build option: PERIPH_BRIDGE_IRQ_SYNC_EN inserts a 2-flop synchroniser ahead of PENDING.
module periph_irq_ctrl
   import periph_bridge_pkg::*;
#(
   parameter int NUM_DEV = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_DEV-1:0]  dev_irq,
   input  logic                wr_mask,
   input  logic                wr_pend,
   input  logic                wr_mode,
   input  logic [NUM_DEV-1:0]  wr_data,
   output logic [NUM_DEV-1:0]  mask,
   output logic [NUM_DEV-1:0]  pending,
   output logic [NUM_DEV-1:0]  mode,
   output logic [HW_INT_W-1:0] hw_int
);

   logic [NUM_DEV-1:0] irq_s, irq_prev, irq_rise, w1c, mode_chg, pending_d;
   logic [MAX_DEV-1:0] active;

`ifdef PERIPH_BRIDGE_IRQ_SYNC_EN
   logic [NUM_DEV-1:0] sync1, sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= dev_irq;
         sync2 <= sync1;
      end
   end

   assign irq_s = sync2;
`else
   // PENDING itself is the single sampling register in this build.
   assign irq_s = dev_irq;
`endif

   assign irq_rise = irq_s & ~irq_prev;
   assign w1c      = wr_pend ? wr_data : '0;
   assign mode_chg = wr_mode ? (wr_data ^ mode) : '0;

   // Level channels follow the input, edge channels latch rises (set beats W1C); a MODE flip clears.
   assign pending_d = ((mode & (irq_rise | (pending & ~w1c))) | (~mode & irq_s)) & ~mode_chg;

   // Channels at or beyond the last HWInt line share that line.
   assign active = MAX_DEV'(pending & mask);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask     <= '0;
         mode     <= '0;
         pending  <= '0;
         irq_prev <= '0;
         hw_int   <= '0;
      end else begin
         if (wr_mask) mask <= wr_data;
         if (wr_mode) mode <= wr_data;
         pending  <= pending_d;
         irq_prev <= irq_s;
         hw_int   <= {|active[MAX_DEV-1:HW_INT_W-1], active[HW_INT_W-2:0]};
      end
   end
endmodule

// File: rtl/periph_bridge.sv
// Peripheral bridge: one bus master to NUM_DEV 16-byte device windows plus an interrupt control window.
// Build option: PERIPH_BRIDGE_IRQ_SYNC_EN adds a 2-flop DevIRQ synchroniser inside periph_irq_ctrl.
module periph_bridge
   import periph_bridge_pkg::*;
#(
   parameter int          NUM_DEV   = 6,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Req,
   input  logic [31:0]           Addr,
   input  logic [31:0]           WD,
   input  logic                  WE,
   output logic                  Ready,
   output logic [31:0]           RD,
   output logic                  Err,
   output logic [7:0]            DevAddr,
   output logic [31:0]           DevWD,
   output logic [NUM_DEV-1:0]    DevWE,
   input  logic [NUM_DEV*32-1:0] DevRD,
   input  logic [NUM_DEV-1:0]    DevIRQ,
   output logic [HW_INT_W-1:0]   HWInt
);

   if (NUM_DEV < 1 || NUM_DEV > MAX_DEV) begin : g_bad_num_dev
      $error("periph_bridge: NUM_DEV must be in 1..8");
   end

   localparam logic [3:0] NUM_DEV_IDX = 4'(NUM_DEV);

   state_t             state, state_d;
   logic [31:0]        addr_q, wd_q, rd_q, rd_d, ctrl_rdata;
   logic               we_q, err_q, err_d;
   logic [3:0]         dev_idx;
   logic               access, in_range, dev_hit, ctrl_hit, ctrl_ok;
   logic               wr_ctrl, wr_mask, wr_pend, wr_mode;
   logic [NUM_DEV-1:0] dev_sel, irq_mask, irq_pend, irq_mode;
   logic [31:0]        dev_rd_arr [MAX_DEV];

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE:   if (Req) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: capture registers are reset as well, since DevAddr/DevWD are driven from them and must read 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         wd_q   <= '0;
         we_q   <= 1'b0;
      end else if (state == ST_IDLE && Req) begin
         addr_q <= Addr;
         wd_q   <= WD;
         we_q   <= WE;
      end
   end

   assign access   = (state == ST_ACCESS);
   assign dev_idx  = addr_q[7:WIN_BITS];
   assign in_range = (addr_q[31:8] == BASE_ADDR[31:8]);
   assign dev_hit  = in_range && (dev_idx < NUM_DEV_IDX);
   assign ctrl_hit = in_range && (&dev_idx);
   assign dev_sel  = NUM_DEV'(1) << dev_idx;

   for (genvar g = 0; g < MAX_DEV; g++) begin : g_rd
      if (g < NUM_DEV) begin : g_used
         assign dev_rd_arr[g] = DevRD[g*32 +: 32];
      end else begin : g_unused
         assign dev_rd_arr[g] = '0;
      end
   end

   always_comb begin
      ctrl_ok    = 1'b1;
      ctrl_rdata = '0;
      case (addr_q[7:0])
         OFF_MASK: ctrl_rdata = 32'(irq_mask);
         OFF_PEND: ctrl_rdata = 32'(irq_pend);
         OFF_MODE: ctrl_rdata = 32'(irq_mode);
         default:  ctrl_ok    = 1'b0;
      endcase
      rd_d  = '0;
      err_d = 1'b1;
      if (dev_hit) begin
         rd_d  = dev_rd_arr[dev_idx[2:0]];
         err_d = 1'b0;
      end else if (ctrl_hit && ctrl_ok) begin
         rd_d  = ctrl_rdata;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q  <= '0;
         err_q <= 1'b0;
      end else if (access) begin
         rd_q  <= rd_d;
         err_q <= err_d;
      end
   end

   assign wr_ctrl = access && we_q && ctrl_hit;
   assign wr_mask = wr_ctrl && (addr_q[7:0] == OFF_MASK);
   assign wr_pend = wr_ctrl && (addr_q[7:0] == OFF_PEND);
   assign wr_mode = wr_ctrl && (addr_q[7:0] == OFF_MODE);

   assign DevWE   = (access && we_q && dev_hit) ? dev_sel : '0;
   assign DevAddr = dev_hit ? 8'(addr_q[WIN_BITS-1:0]) : addr_q[7:0];
   assign DevWD   = wd_q;
   assign Ready   = (state == ST_RESP);
   assign RD      = rd_q;
   assign Err     = err_q;

   periph_irq_ctrl #(.NUM_DEV(NUM_DEV)) u_irq (
      .clk     (clk),
      .reset   (reset),
      .dev_irq (DevIRQ),
      .wr_mask (wr_mask),
      .wr_pend (wr_pend),
      .wr_mode (wr_mode),
      .wr_data (wd_q[NUM_DEV-1:0]),
      .mask    (irq_mask),
      .pending (irq_pend),
      .mode    (irq_mode),
      .hw_int  (HWInt)
   );
endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge: a 6-channel and an 8-channel instance share one bus master.
module tb_periph_bridge;
`ifdef PERIPH_BRIDGE_IRQ_SYNC_EN
   localparam int PLAT = 3;
`else
   localparam int PLAT = 1;
`endif

   logic         clk = 1'b0;
   logic         reset, Req, WE;
   logic [31:0]  Addr, WD;
   logic [255:0] dev_rd;
   logic [7:0]   dev_irq;

   logic        ready6, err6, ready8, err8;
   logic [31:0] rd6, dev_wd6, rd8, dev_wd8;
   logic [7:0]  dev_addr6, dev_addr8, dev_we8;
   logic [5:0]  dev_we6, hw6, hw8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   periph_bridge dut6 (
      .clk(clk), .reset(reset), .Req(Req), .Addr(Addr), .WD(WD), .WE(WE),
      .Ready(ready6), .RD(rd6), .Err(err6), .DevAddr(dev_addr6), .DevWD(dev_wd6),
      .DevWE(dev_we6), .DevRD(dev_rd[191:0]), .DevIRQ(dev_irq[5:0]), .HWInt(hw6)
   );

   periph_bridge #(.NUM_DEV(8)) dut8 (
      .clk(clk), .reset(reset), .Req(Req), .Addr(Addr), .WD(WD), .WE(WE),
      .Ready(ready8), .RD(rd8), .Err(err8), .DevAddr(dev_addr8), .DevWD(dev_wd8),
      .DevWE(dev_we8), .DevRD(dev_rd), .DevIRQ(dev_irq), .HWInt(hw8)
   );

   // One bus transaction on dut6; reports latency to Ready and the device-side activity seen.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic [5:0] we_or, output int we_cyc,
                       output logic [7:0] da, output logic [31:0] dw);
      @(negedge clk);
      Req = 1'b1; WE = w; Addr = a; WD = d;
      lat = -1; we_or = '0; we_cyc = 0; da = '0; dw = '0; rd = '0; er = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (dev_we6 != 6'b0) begin
            we_cyc++;
            we_or |= dev_we6;
         end
         if (c == 1) begin
            da = dev_addr6;
            dw = dev_wd6;
         end
         if (ready6) begin
            lat = c;
            rd  = rd6;
            er  = err6;
            break;
         end
      end
      Req = 1'b0; WE = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (ready6 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready6); end
      checks++; if (rd6 !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd6); end
      checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err6); end
      checks++; if (dev_we6 !== 6'h0) begin errors++; $display("FAIL reset_devwe: got %b want 0", dev_we6); end
      checks++; if (dev_addr6 !== 8'h0) begin errors++; $display("FAIL reset_devaddr: got %h want 0", dev_addr6); end
      checks++; if (dev_wd6 !== 32'h0) begin errors++; $display("FAIL reset_devwd: got %h want 0", dev_wd6); end
      checks++; if (hw6 !== 6'h0) begin errors++; $display("FAIL reset_hwint: got %b want 0", hw6); end
      reset = 1'b0;
   endtask

   task automatic test_write();
      logic [31:0] rd, dw; logic er; int lat, wc; logic [5:0] wo; logic [7:0] da;
      xfer(1'b1, 32'h7F14, 32'hDEADBEEF, rd, er, lat, wo, wc, da, dw);
      checks++; if (wo !== 6'b000010) begin errors++; $display("FAIL write_devwe: got %b want 000010", wo); end
      checks++; if (wc != 1) begin errors++; $display("FAIL write_devwe_cycles: got %0d want 1", wc); end
      checks++; if (da !== 8'h04) begin errors++; $display("FAIL write_devaddr: got %h want 04", da); end
      checks++; if (dw !== 32'hDEADBEEF) begin errors++; $display("FAIL write_devwd: got %h want deadbeef", dw); end
      checks++; if (lat != 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL write_err: got %b want 0", er); end
      @(negedge clk);
      checks++; if ({dev_we6, dev_addr6} !== {6'b0, 8'h04}) begin
         errors++; $display("FAIL write_hold: got we=%b addr=%h want we=0 addr=04", dev_we6, dev_addr6);
      end
   endtask

   task automatic test_read();
      logic [31:0] rd, dw; logic er; int lat, wc; logic [5:0] wo; logic [7:0] da;
      logic [31:0] a_t [5];
      logic [31:0] rd_t [5];
      logic        er_t [5];
      logic        w_t  [5];
      a_t  = '{32'h7F28, 32'h7F5C, 32'h7F80, 32'h7F60, 32'h8F28};
      rd_t = '{32'h12345678, 32'hA5A50005, 32'h0, 32'h0, 32'h0};
      er_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      w_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         xfer(w_t[i], a_t[i], 32'hFFFF_FFFF, rd, er, lat, wo, wc, da, dw);
         checks++; if (rd !== rd_t[i]) begin errors++; $display("FAIL read_rd[%h]: got %h want %h", a_t[i], rd, rd_t[i]); end
         checks++; if (er !== er_t[i]) begin errors++; $display("FAIL read_err[%h]: got %b want %b", a_t[i], er, er_t[i]); end
         checks++; if (lat != 2) begin errors++; $display("FAIL read_latency[%h]: got %0d want 2", a_t[i], lat); end
         checks++; if (wc != 0) begin errors++; $display("FAIL read_no_devwe[%h]: got %0d cycles want 0", a_t[i], wc); end
      end
      xfer(1'b1, 32'h7FFC, 32'hFF, rd, er, lat, wo, wc, da, dw);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL ctrl_unimpl_err: got %b want 1", er); end
      checks++; if (wc != 0) begin errors++; $display("FAIL ctrl_unimpl_devwe: got %0d want 0", wc); end
      xfer(1'b0, 32'h7FF0, 32'h0, rd, er, lat, wo, wc, da, dw);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_unimpl_ignored: mask got %h want 0", rd); end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  pat = '0;
      logic [31:0] rd2 = '0;
      @(negedge clk);
      Req = 1'b1; WE = 1'b0; Addr = 32'h7F28;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         pat = {ready6, pat[5:1]};
         if (k == 5) rd2 = rd6;
      end
      Req = 1'b0;
      checks++; if (pat !== 6'b010010) begin errors++; $display("FAIL b2b_ready_pattern: got %b want 010010", pat); end
      checks++; if (rd2 !== 32'h12345678) begin errors++; $display("FAIL b2b_second_rd: got %h want 12345678", rd2); end
   endtask

   task automatic test_irq_edge();
      logic [31:0] rd, dw; logic er; int lat, wc; logic [5:0] wo; logic [7:0] da;
      xfer(1'b1, 32'h7FF8, 32'h1, rd, er, lat, wo, wc, da, dw);
      xfer(1'b1, 32'h7FF0, 32'h1, rd, er, lat, wo, wc, da, dw);
      @(negedge clk);
      dev_irq[0] = 1'b1;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         dev_irq[0] = 1'b0;
         if (hw6[0] && lat < 0) lat = k;
      end
      checks++; if (lat != PLAT + 1) begin errors++; $display("FAIL irq_edge_latency: got %0d want %0d", lat, PLAT + 1); end
      checks++; if (hw6 !== 6'b000001) begin errors++; $display("FAIL irq_edge_held: got %b want 000001", hw6); end
      xfer(1'b0, 32'h7FF4, 32'h0, rd, er, lat, wo, wc, da, dw);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL pending_read: got %h want 1", rd); end
      xfer(1'b1, 32'h7FF4, 32'h1, rd, er, lat, wo, wc, da, dw);
      @(negedge clk);
      checks++; if (hw6 !== 6'b0) begin errors++; $display("FAIL w1c_clear: got %b want 0", hw6); end
      // Time the input rise so the detected edge lands on the same clock as the W1C write.
      fork
         begin
            @(negedge clk);
            xfer(1'b1, 32'h7FF4, 32'h1, rd, er, lat, wo, wc, da, dw);
         end
         begin
            repeat (4 - PLAT) @(negedge clk);
            dev_irq[0] = 1'b1;
         end
      join
      @(negedge clk);
      checks++; if (hw6 !== 6'b000001) begin errors++; $display("FAIL w1c_set_wins: got %b want 000001", hw6); end
      xfer(1'b1, 32'h7FF8, 32'h0, rd, er, lat, wo, wc, da, dw);
      xfer(1'b1, 32'h7FF4, 32'h1, rd, er, lat, wo, wc, da, dw);
      xfer(1'b0, 32'h7FF4, 32'h0, rd, er, lat, wo, wc, da, dw);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL level_w1c_ignored: got %h want 1", rd); end
      xfer(1'b1, 32'h7FF8, 32'h1, rd, er, lat, wo, wc, da, dw);
      xfer(1'b0, 32'h7FF4, 32'h0, rd, er, lat, wo, wc, da, dw);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mode_change_clear: got %h want 0", rd); end
      dev_irq[0] = 1'b0;
   endtask

   task automatic test_hw5();
      logic [31:0] rd, dw; logic er; int lat, wc; logic [5:0] wo; logic [7:0] da;
      xfer(1'b1, 32'h7FF8, 32'h0, rd, er, lat, wo, wc, da, dw);
      xfer(1'b1, 32'h7FF0, 32'hC0, rd, er, lat, wo, wc, da, dw);
      @(negedge clk);
      dev_irq[7] = 1'b1;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (hw8 == 6'b100000 && lat < 0) lat = k;
      end
      checks++; if (lat != PLAT + 1) begin errors++; $display("FAIL hw5_latency: got %0d want %0d", lat, PLAT + 1); end
      checks++; if (hw8 !== 6'b100000) begin errors++; $display("FAIL hw5_level_held: got %b want 100000", hw8); end
      checks++; if (hw6 !== 6'b0) begin errors++; $display("FAIL hw5_six_ch_none: got %b want 0", hw6); end
      dev_irq[7] = 1'b0;
      repeat (PLAT) @(negedge clk);
      checks++; if (hw8 !== 6'b100000) begin errors++; $display("FAIL hw5_before_drop: got %b want 100000", hw8); end
      @(negedge clk);
      checks++; if (hw8 !== 6'b0) begin errors++; $display("FAIL hw5_drop: got %b want 0", hw8); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd, dw; logic er; int lat, wc; logic [5:0] wo; logic [7:0] da;
      logic seen = 1'b0;
      xfer(1'b1, 32'h7FF0, 32'h3F, rd, er, lat, wo, wc, da, dw);
      @(negedge clk);
      Req = 1'b1; WE = 1'b1; Addr = 32'h7F00; WD = 32'h55;
      @(negedge clk);
      checks++; if (dev_we6 !== 6'b000001) begin errors++; $display("FAIL abort_access_we: got %b want 000001", dev_we6); end
      reset = 1'b1;
      #1;
      checks++; if (dev_we6 !== 6'b0) begin errors++; $display("FAIL abort_we_cleared: got %b want 0", dev_we6); end
      @(negedge clk);
      Req = 1'b0; WE = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (ready6 || dev_we6 != 6'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got activity=1 want 0"); end
      checks++; if ({rd6, err6, dev_addr6, dev_wd6, hw6, hw8} !== 85'd0) begin
         errors++; $display("FAIL abort_outputs_zero: got rd=%h err=%b addr=%h wd=%h hw=%b want all 0", rd6, err6, dev_addr6, dev_wd6, hw6);
      end
      xfer(1'b0, 32'h7FF0, 32'h0, rd, er, lat, wo, wc, da, dw);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_mask: got %h want 0", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL post_reset_err: got %b want 0", er); end
      checks++; if (lat != 2) begin errors++; $display("FAIL post_reset_latency: got %0d want 2", lat); end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; Req = 1'b0; WE = 1'b0; Addr = '0; WD = '0; dev_irq = '0;
      for (int i = 0; i < 8; i++) dev_rd[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
      dev_rd[2*32 +: 32] = 32'h12345678;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_irq_edge();
      test_hw5();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
